mdu_sched: RTL and testbench
============================

# mdu_sched

Multi-cycle multiply/divide sequencer and HI/LO register owner for the pipelined CPU. It takes the decoded HILO operation of the E-stage instruction, runs multiplies and divides over a fixed number of cycles, serves mthi/mtlo/mfhi/mflo, and raises the D-stage stall request that holds back any md/mt/mf instruction while the unit is busy.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- hilo_type_e  in  4  E-stage HILO code: none=0, mult=1, multu=2, div=3, divu=4, mthi=5, mtlo=6, mfhi=7, mflo=8; values >8 treated as none
- rs_e  in  32  forwarded rs value in E
- rt_e  in  32  forwarded rt value in E
- hilo_use_d  in  1  D-stage instruction is md, mt or mf
- start  out  1  combinational; md code in E while IDLE
- busy  out  1  registered; multi-cycle operation in progress
- stall_d  out  1  combinational; hilo_use_d && (start || busy)
- hi  out  32  HI register
- lo  out  32  LO register
- hilo_rdata_e  out  32  combinational; hi for mfhi, lo for mflo, else 0

## Operation
- States: IDLE, MULT, DIV. Counter cnt, 5 bits wide enough for max(MULT_CYCLES, DIV_CYCLES).
- IDLE, md code in E: start=1; compute result at this edge into res_hi/res_lo; load cnt with MULT_CYCLES or DIV_CYCLES; go to MULT or DIV.
- MULT/DIV: busy=1; cnt decrements each cycle; when cnt==1 on a clock edge: commit res_hi→hi, res_lo→lo, return to IDLE.
- mult: signed 32×32→64, {hi,lo}=product. multu: unsigned.
- div: lo=signed quotient truncated toward zero, hi=remainder with sign of dividend. 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divide by zero (rt_e==0): full DIV_CYCLES busy period, no commit; hi/lo unchanged.
- mthi/mtlo in E while IDLE: hi (resp. lo) ← rs_e at the edge; no busy.
- mf reads current hi/lo combinationally; stall_d guarantees no mf reaches E while busy.
- md/mt code in E while busy: ignored; no state change (protocol violation, prevented by stall_d).
- Operands are latched at start; rs_e/rt_e changes during busy have no effect.

## Timing
- Reset values: state IDLE, cnt=0, busy=0, hi=0, lo=0, res_hi=res_lo=0; start/stall_d/hilo_rdata_e follow inputs combinationally.
- md in E at cycle t: start=1 in t; busy=1 in t+1 … t+N (N=MULT_CYCLES or DIV_CYCLES); hi/lo update at end of t+N; visible from t+N+1; busy=0 in t+N+1.
- Back-to-back: next md may be in E at t+N+1 and starts immediately.
- stall_d covers D-stage md/mt/mf in cycles t … t+N; released at t+N+1.
- mthi/mtlo in E at t: new value visible on hi/lo at t+1; mf in E at t+1 reads it.
- reset asserted mid-operation: next edge returns to reset values; pending result discarded, no commit.

## Test plan
- After reset: hi=lo=0, busy=0; mthi rs=0x12345678 → hi=0x12345678 next cycle; mflo in E → hilo_rdata_e=0.
- mult rs=0xFFFFFFFE, rt=3 → busy cycles 1–5, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu same operands → hi=0x2, lo=0xFFFFFFFA.
- div rs=0xFFFFFFF9 (-7), rt=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 → 10 busy cycles, hi/lo unchanged.
- mult in E with mflo in D → stall_d=1 for 6 cycles (start + 5 busy), mflo then reads new lo; unrelated D instr (hilo_use_d=0) never stalled.
- reset pulsed at busy cycle 3 of div → busy=0, hi=lo=0 next cycle, no later commit.
- div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0; second md issued cycle after busy drops starts without extra bubble.

Source files
------------

// File: rtl/mdu_sched_if.sv
// E/D-stage connection between the pipeline and the multiply/divide sequencer.
// The pipeline drives decoded HILO controls and operands; the unit returns status and HI/LO.
interface mdu_sched_if;
    logic [3:0]  hilo_type_e;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        hilo_use_d;
    logic        start;
    logic        busy;
    logic        stall_d;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hilo_rdata_e;

    modport master (
        output hilo_type_e, rs_e, rt_e, hilo_use_d,
        input  start, busy, stall_d, hi, lo, hilo_rdata_e
    );

    modport slave (
        input  hilo_type_e, rs_e, rt_e, hilo_use_d,
        output start, busy, stall_d, hi, lo, hilo_rdata_e
    );
endinterface

// File: rtl/mdu_sched.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; the result is computed at start
// and held until the busy period ends, modelling a fixed-latency iterative unit.
module mdu_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_sched_if.slave bus
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } hilo_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

    state_t      state, state_next;
    logic [4:0]  cnt, cnt_next;
    logic [31:0] hi, lo;
    logic [31:0] res_hi, res_lo;
    logic        res_ok;

    hilo_op_t    op;
    logic [31:0] op_a, op_b;
    logic        is_mul, is_div, is_signed, is_md;
    logic        start, commit;
    logic        mt_hi, mt_lo;

    assign op   = hilo_op_t'(bus.hilo_type_e);
    assign op_a = bus.rs_e;
    assign op_b = bus.rt_e;

    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign is_md     = is_mul || is_div;

    // ------------------------------------------------------------------
    // Arithmetic, evaluated on the operands present in the start cycle
    // ------------------------------------------------------------------
    logic        sext_a, sext_b;
    logic [63:0] prod;
    logic [31:0] dvd, dvs, dvs_safe, quot, rem, quot_fix, rem_fix;
    logic        div_by_zero;
    logic [31:0] res_hi_next, res_lo_next;

    assign sext_a = is_signed & op_a[31];
    assign sext_b = is_signed & op_b[31];
    // Low 64 bits of the sign-extended product equal the exact signed product.
    assign prod   = {{32{sext_a}}, op_a} * {{32{sext_b}}, op_b};

    // Signed divide works on magnitudes and re-applies signs, which also yields
    // 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
    assign dvd         = sext_a ? (32'd0 - op_a) : op_a;
    assign dvs         = sext_b ? (32'd0 - op_b) : op_b;
    assign div_by_zero = is_div && (op_b == 32'd0);
    assign dvs_safe    = (op_b == 32'd0) ? 32'd1 : dvs;
    assign quot        = dvd / dvs_safe;
    assign rem         = dvd % dvs_safe;
    assign quot_fix    = (sext_a ^ sext_b) ? (32'd0 - quot) : quot;
    assign rem_fix     = sext_a ? (32'd0 - rem) : rem;

    assign res_hi_next = is_mul ? prod[63:32] : rem_fix;
    assign res_lo_next = is_mul ? prod[31:0]  : quot_fix;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        state_next = state;
        cnt_next   = cnt;
        start      = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (is_md) begin
                    start      = 1'b1;
                    cnt_next   = is_mul ? MULT_LOAD : DIV_LOAD;
                    state_next = is_mul ? MULT : DIV;
                end
            end
            MULT, DIV: begin
                if (cnt == 5'd1) begin
                    commit     = res_ok;
                    cnt_next   = 5'd0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 5'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 5'd0;
            end
        endcase
    end

    // Moves only act while idle; md/mt codes arriving during busy are dropped.
    assign mt_hi = (state == IDLE) && (op == OP_MTHI);
    assign mt_lo = (state == IDLE) && (op == OP_MTLO);

    // ------------------------------------------------------------------
    // Result staging and HI/LO ownership
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_ok <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            if (start) begin
                res_hi <= res_hi_next;
                res_lo <= res_lo_next;
                res_ok <= !div_by_zero;
            end
            if (commit) begin
                hi <= res_hi;
                lo <= res_lo;
            end else begin
                if (mt_hi) hi <= op_a;
                if (mt_lo) lo <= op_a;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.start        = start;
    assign bus.busy         = (state != IDLE);
    assign bus.stall_d      = bus.hilo_use_d && (start || (state != IDLE));
    assign bus.hi           = hi;
    assign bus.lo           = lo;
    assign bus.hilo_rdata_e = (op == OP_MFHI) ? hi :
                              (op == OP_MFLO) ? lo : 32'd0;

endmodule

// File: tb/tb_mdu_sched.sv
// Randomized scoreboard bench for mdu_sched: a reference model predicts HI/LO and
// busy length per operation, and a monitor checks them whenever busy drops.
module tb_mdu_sched;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] T_NONE  = 4'd0;
    localparam logic [3:0] T_MULT  = 4'd1;
    localparam logic [3:0] T_MULTU = 4'd2;
    localparam logic [3:0] T_DIV   = 4'd3;
    localparam logic [3:0] T_DIVU  = 4'd4;
    localparam logic [3:0] T_MTHI  = 4'd5;
    localparam logic [3:0] T_MTLO  = 4'd6;
    localparam logic [3:0] T_MFHI  = 4'd7;
    localparam logic [3:0] T_MFLO  = 4'd8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mdu_sched_if bus ();

    mdu_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          len;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic in 64-bit integers; divide by zero leaves HI/LO as they are.
    function automatic void ref_md(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] h, inout logic [31:0] l);
        int          sa, sbv;
        longint      p, q, r;
        logic [63:0] u;
        sa  = a;
        sbv = b;
        case (code)
            T_MULT: begin
                p = longint'(sa) * longint'(sbv);
                u = p;
                h = u[63:32];
                l = u[31:0];
            end
            T_MULTU: begin
                u = {32'd0, a} * {32'd0, b};
                h = u[63:32];
                l = u[31:0];
            end
            T_DIV: if (b != 32'd0) begin
                q = longint'(sa) / longint'(sbv);
                r = longint'(sa) % longint'(sbv);
                u = q;
                l = u[31:0];
                u = r;
                h = u[31:0];
            end
            T_DIVU: if (b != 32'd0) begin
                l = a / b;
                h = a % b;
            end
            default: ;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one md op at the current cycle t and returns in cycle t+N+1.
    task automatic issue_md(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                            input logic use_d);
        exp_t e;
        int   n;
        int   stalls;
        stalls = 0;
        n      = (code == T_MULT || code == T_MULTU) ? MC : DC;
        ref_md(code, a, b, m_hi, m_lo);
        e.len  = n;
        e.hi   = m_hi;
        e.lo   = m_lo;
        e.name = $sformatf("md%0d", code);
        exp_q.push_back(e);
        bus.hilo_type_e = code;
        bus.rs_e        = a;
        bus.rt_e        = b;
        bus.hilo_use_d  = use_d;
        @(negedge clk);
        check("start", bus.start, 1);
        stalls += int'(bus.stall_d);
        tick();
        repeat (n) begin
            bus.hilo_type_e = 4'($urandom_range(0, 15));
            bus.rs_e        = $urandom;
            bus.rt_e        = $urandom;
            @(negedge clk);
            stalls += int'(bus.stall_d);
            tick();
        end
        bus.hilo_type_e = T_NONE;
        check("stall_cycles", stalls, use_d ? n + 1 : 0);
    endtask

    task automatic do_mt(input logic [3:0] code, input logic [31:0] val);
        bus.hilo_type_e = code;
        bus.rs_e        = val;
        @(negedge clk);
        check("mt_no_start", bus.start, 0);
        tick();
        bus.hilo_type_e = T_NONE;
        if (code == T_MTHI) m_hi = val;
        else m_lo = val;
        @(negedge clk);
        check("mt_hi", bus.hi, m_hi);
        check("mt_lo", bus.lo, m_lo);
        check("mt_busy", bus.busy, 0);
        tick();
    endtask

    task automatic do_mf(input logic [3:0] code);
        bus.hilo_type_e = code;
        @(negedge clk);
        check("mf_rdata", bus.hilo_rdata_e, (code == T_MFHI) ? m_hi : m_lo);
        tick();
        bus.hilo_type_e = T_NONE;
    endtask

    // Monitor: every falling edge of busy retires one scoreboard entry.
    int   busy_len  = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.busy === 1'b1) begin
            busy_len++;
        end else if (prev_busy) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({e.name, "_busy_len"}, busy_len, e.len);
                check({e.name, "_hi"}, bus.hi, e.hi);
                check({e.name, "_lo"}, bus.lo, e.lo);
            end
            busy_len = 0;
        end
        prev_busy = (bus.busy === 1'b1);
    end

    initial begin
        exp_t        e;
        logic [3:0]  code;
        logic [31:0] a, b;

        bus.hilo_type_e = T_NONE;
        bus.rs_e        = 32'd0;
        bus.rt_e        = 32'd0;
        bus.hilo_use_d  = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_start", bus.start, 0);
        tick();

        // mthi then mf in the very next cycle
        do_mt(T_MTHI, 32'h1234_5678);
        do_mf(T_MFLO);
        do_mf(T_MFHI);

        // mult with a dependent mflo in D
        issue_md(T_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
        bus.hilo_type_e = T_MFLO;
        @(negedge clk);
        check("stall_release", bus.stall_d, 0);
        check("mult_lo_rd", bus.hilo_rdata_e, 32'hFFFF_FFFA);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        tick();
        bus.hilo_type_e = T_NONE;
        bus.hilo_use_d  = 1'b0;

        issue_md(T_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        @(negedge clk);
        check("multu_hi", bus.hi, 32'h2);
        check("multu_lo", bus.lo, 32'hFFFF_FFFA);
        tick();

        issue_md(T_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        @(negedge clk);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);
        tick();

        issue_md(T_DIVU, 32'd7, 32'd0, 1'b0);
        @(negedge clk);
        check("div0_hi", bus.hi, 32'hFFFF_FFFF);
        check("div0_lo", bus.lo, 32'hFFFF_FFFD);
        tick();

        issue_md(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        check("ovf_lo", bus.lo, 32'h8000_0000);
        check("ovf_hi", bus.hi, 32'h0);
        tick();

        // back-to-back: second op enters E in the cycle busy drops
        issue_md(T_MULT, 32'h0001_0003, 32'hFFFF_0007, 1'b1);
        issue_md(T_DIV, 32'd1000, 32'hFFFF_FFFD, 1'b1);
        issue_md(T_MULTU, $urandom, $urandom, 1'b0);
        bus.hilo_use_d = 1'b0;

        // reset during busy cycle 3 of a divide discards the result
        e.len = 3; e.hi = 32'd0; e.lo = 32'd0; e.name = "div_reset";
        exp_q.push_back(e);
        bus.hilo_type_e = T_DIV;
        bus.rs_e        = 32'd100;
        bus.rt_e        = 32'd7;
        tick();
        bus.hilo_type_e = T_NONE;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        @(negedge clk);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_hi", bus.hi, 0);
        check("rst_mid_lo", bus.lo, 0);
        repeat (DC + 2) tick();
        @(negedge clk);
        check("no_late_hi", bus.hi, 0);
        check("no_late_lo", bus.lo, 0);
        tick();

        // random mix, including ignored out-of-range codes
        for (int i = 0; i < 40; i++) begin
            code = 4'($urandom_range(0, 15));
            a    = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if (code >= T_MULT && code <= T_DIVU) begin
                issue_md(code, a, b, 1'($urandom_range(0, 1)));
                bus.hilo_use_d = 1'b0;
            end else if (code == T_MTHI || code == T_MTLO) begin
                do_mt(code, a);
            end else if (code == T_MFHI || code == T_MFLO) begin
                do_mf(code);
            end else begin
                bus.hilo_type_e = code;
                bus.rs_e        = a;
                bus.rt_e        = b;
                bus.hilo_use_d  = 1'b1;
                @(negedge clk);
                check("none_start", bus.start, 0);
                check("none_stall", bus.stall_d, 0);
                check("none_rdata", bus.hilo_rdata_e, 0);
                tick();
                bus.hilo_type_e = T_NONE;
                bus.hilo_use_d  = 1'b0;
                @(negedge clk);
                check("none_busy", bus.busy, 0);
                check("none_hi", bus.hi, m_hi);
                check("none_lo", bus.lo, m_lo);
                tick();
            end
        end

        repeat (3) tick();
        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
